// File: rtl/seq_fir_mac_if.sv
// seq_fir_mac_if
//  Bundles the sample-input handshake, the coefficient write port and the
//  result-output handshake of seq_fir_mac into one interface.
//  Ports (members):
//   in_valid/in_ready/in_data       sample source -> filter (valid/ready)
//   coef_we/coef_addr/coef_data     runtime coefficient write port
//   out_valid/out_ready/out_data    filter -> downstream (valid/ready)
//   busy                            filter is in its MAC or OUT phase
//  Modports: master = the environment (source/sink), slave = the filter.
interface seq_fir_mac_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int AW    = $clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic        [AW-1:0]     coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     busy;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/seq_fir_mac.sv
// seq_fir_mac
//  Time-multiplexed FIR filter built around a single multiply-accumulate.
//  Each accepted sample is pushed into an x delay line and then TAPS edges
//  are spent computing y = sum h[k]*x[k] at full precision. The result is
//  presented with a valid/ready handshake; coefficients are writable while
//  the filter is idle.
//  Ports:
//   sclk   clock, rising edge
//   s_rst  synchronous active-high reset
//   bus    seq_fir_mac_if.slave (sample in, coefficient write, result out, busy)
module seq_fir_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8
) (
    input logic          sclk,
    input logic          s_rst,
    seq_fir_mac_if.slave bus
);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] x_line [TAPS];
    logic signed [COEF_W-1:0] h_coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic        [AW-1:0]     k;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;

    // The one multiplier: both operands are sign-extended to the full product
    // width first, and the product is sign-extended again before it joins the
    // accumulator, so no intermediate step can wrap.
    always_comb begin
        prod = PROD_W'(x_line[k]) * PROD_W'(h_coef[k]);
        sum  = acc + ACC_W'(prod);
    end

    // Control FSM plus datapath registers. in_ready, busy and out_valid are
    // registered alongside the state so they change exactly when the state does.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state         <= IDLE;
            acc           <= '0;
            k             <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
            for (int i = 0; i < TAPS; i++) begin
                x_line[i] <= '0;
                h_coef[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A coefficient written on the accept edge lands before
                    // the MAC pass reads it, so that sample already uses it.
                    if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
                        h_coef[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.in_valid && bus.in_ready) begin
                        x_line[0] <= bus.in_data;
                        for (int i = 1; i < TAPS; i++) begin
                            x_line[i] <= x_line[i-1];
                        end
                        acc          <= '0;
                        k            <= '0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        bus.out_data  <= sum;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
